// File: rtl/rect_draw_engine_if.sv
// Request / pixel-port bundle for rect_draw_engine.
// master = requester + VGA consumer side, slave = the engine.
interface rect_draw_engine_if #(
    parameter int COLOUR_W = 3
);
    logic                req_valid;
    logic                req_ready;
    logic [7:0]          req_x0;
    logic [6:0]          req_y0;
    logic [7:0]          req_w;
    logic [6:0]          req_h;
    logic [COLOUR_W-1:0] req_colour;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                done;
    logic                busy;

    modport master (
        output req_valid, req_x0, req_y0, req_w, req_h, req_colour,
        input  req_ready, x, y, colour, plot, done, busy
    );

    modport slave (
        input  req_valid, req_x0, req_y0, req_w, req_h, req_colour,
        output req_ready, x, y, colour, plot, done, busy
    );
endinterface

// File: rtl/rect_draw_engine.sv
// Filled axis-aligned rectangle rasteriser for the 160x120 VGA adapter.
// One clipped pixel per clock, row-major, then a one-cycle done pulse.
module rect_draw_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOUR_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
    rect_draw_engine_if.slave  bus
);
    localparam logic [8:0] SW9 = 9'(SCREEN_W);
    localparam logic [7:0] SW8 = 8'(SCREEN_W);
    localparam logic [7:0] SH8 = 8'(SCREEN_H);
    localparam logic [6:0] SH7 = 7'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t              state_q, state_n;
    logic [7:0]          x_q, x_n;
    logic [6:0]          y_q, y_n;
    logic [COLOUR_W-1:0] colour_q, colour_n;
    logic                plot_q, plot_n;
    logic                done_q, done_n;
    logic [7:0]          x0_q, x0_n;
    logic [7:0]          xl_q, xl_n;
    logic [6:0]          yl_q, yl_n;

    logic [8:0]          x_end;
    logic [7:0]          y_end;
    logic [7:0]          ew;
    logic [6:0]          eh;

    // Clip the incoming request to the visible area (wide sums avoid wrap).
    always_comb begin
        x_end = {1'b0, bus.req_x0} + {1'b0, bus.req_w};
        y_end = {1'b0, bus.req_y0} + {1'b0, bus.req_h};
        if (bus.req_x0 >= SW8)
            ew = 8'd0;
        else if (x_end > SW9)
            ew = SW8 - bus.req_x0;
        else
            ew = bus.req_w;
        if (bus.req_y0 >= SH7)
            eh = 7'd0;
        else if (y_end > SH8)
            eh = SH7 - bus.req_y0;
        else
            eh = bus.req_h;
    end

    // Next state and next registered outputs.
    always_comb begin
        state_n  = state_q;
        x_n      = x_q;
        y_n      = y_q;
        colour_n = colour_q;
        plot_n   = 1'b0;
        done_n   = 1'b0;
        x0_n     = x0_q;
        xl_n     = xl_q;
        yl_n     = yl_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    colour_n = bus.req_colour;
                    if (ew == 8'd0 || eh == 7'd0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = DRAW;
                        plot_n  = 1'b1;
                        x_n     = bus.req_x0;
                        y_n     = bus.req_y0;
                        x0_n    = bus.req_x0;
                        xl_n    = bus.req_x0 + ew - 8'd1;
                        yl_n    = bus.req_y0 + eh - 7'd1;
                    end
                end
            end
            DRAW: begin
                if (x_q == xl_q && y_q == yl_q) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (x_q == xl_q) begin
                    plot_n = 1'b1;
                    x_n    = x0_q;
                    y_n    = y_q + 7'd1;
                end else begin
                    plot_n = 1'b1;
                    x_n    = x_q + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            x0_q     <= 8'd0;
            xl_q     <= 8'd0;
            yl_q     <= 7'd0;
        end else begin
            state_q  <= state_n;
            x_q      <= x_n;
            y_q      <= y_n;
            colour_q <= colour_n;
            plot_q   <= plot_n;
            done_q   <= done_n;
            x0_q     <= x0_n;
            xl_q     <= xl_n;
            yl_q     <= yl_n;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = colour_q;
    assign bus.plot      = plot_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: directed and random rectangles checked
// pixel by pixel against a clipped-rectangle reference model.
module tb_rect_draw_engine;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rect_draw_engine_if #(.COLOUR_W(3)) bus ();

    rect_draw_engine #(
        .SCREEN_W(160),
        .SCREEN_H(120),
        .COLOUR_W(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(int x0, int y0, int w, int h, int col);
        bus.req_valid  = 1'b1;
        bus.req_x0     = 8'(x0);
        bus.req_y0     = 7'(y0);
        bus.req_w      = 8'(w);
        bus.req_h      = 7'(h);
        bus.req_colour = 3'(col);
    endtask

    task automatic scramble_req();
        bus.req_x0     = 8'($urandom);
        bus.req_y0     = 7'($urandom);
        bus.req_w      = 8'($urandom);
        bus.req_h      = 7'($urandom);
        bus.req_colour = 3'($urandom);
    endtask

    // Issue one rectangle and check every cycle until ready returns.
    // poke >= 0 raises a bogus request while drawing pixel index poke.
    task automatic run_req(string tag, int x0, int y0, int w, int h,
                           int col, int poke);
        int qx[$];
        int qy[$];
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                if (xx < 160 && yy < 120) begin
                    qx.push_back(xx);
                    qy.push_back(yy);
                end
        @(negedge clk);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        drive_req(x0, y0, w, h, col);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        scramble_req();
        for (int k = 0; k < qx.size(); k++) begin
            check({tag, ".pix"},
                  32'({bus.plot, bus.x, bus.y, bus.colour}),
                  32'({1'b1, 8'(qx[k]), 7'(qy[k]), 3'(col)}));
            if (k == poke) begin
                bus.req_valid = 1'b1;
                scramble_req();
            end
            if (k == poke + 2)
                bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        check({tag, ".donecyc"},
              32'({bus.plot, bus.done, bus.busy, bus.req_ready}),
              32'(4'b0110));
        @(posedge clk);
        #1;
        check({tag, ".after"},
              32'({bus.plot, bus.done, bus.busy, bus.req_ready}),
              32'(4'b0001));
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_x0     = 8'd0;
        bus.req_y0     = 7'd0;
        bus.req_w      = 8'd0;
        bus.req_h      = 7'd0;
        bus.req_colour = 3'd0;

        // reset held two cycles
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ctl",
              32'({bus.plot, bus.done, bus.busy, bus.req_ready}),
              32'(4'b0001));
        check("reset.pix", 32'({bus.x, bus.y, bus.colour}), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_req("basic", 10, 20, 3, 2, 4, -1);
        run_req("clip", 158, 118, 4, 4, 5, -1);
        run_req("w0", 30, 30, 0, 5, 2, -1);
        run_req("h0", 30, 30, 5, 0, 2, -1);
        run_req("x200", 200, 10, 5, 5, 1, -1);
        run_req("y125", 5, 125, 5, 5, 1, -1);
        run_req("wide", 100, 5, 255, 2, 6, -1);
        run_req("tall", 3, 100, 2, 127, 7, -1);
        run_req("corner", 159, 119, 1, 1, 3, -1);
        run_req("busy", 40, 50, 5, 4, 6, 3);

        // reset in the middle of a draw
        @(negedge clk);
        drive_req(10, 10, 10, 10, 5);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid.plotting", 32'(bus.plot), 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("mid.abort",
              32'({bus.plot, bus.done, bus.busy, bus.req_ready}),
              32'(4'b0001));
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mid.quiet", 32'({bus.plot, bus.done}), 32'd0);
        end

        // random rectangles, often straddling the edges
        for (int i = 0; i < 16; i++)
            run_req("rand",
                    int'($urandom_range(0, 215)),
                    int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 60)),
                    int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 7)), -1);

        run_req("full", 0, 0, 160, 120, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
